// File: rtl/dllp_tx_arbiter.sv
// Arbitrates ACK/NAK, UpdateFC and TLP AXI-Stream sources onto one PHY-bound stream.
// DLLPs win by default; a TLP waiting through STARVE_LIMIT DLLP grants takes priority.
module dllp_tx_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
  parameter int USER_WIDTH   = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  phy_link_up_i,

  input  logic [DATA_WIDTH-1:0] s_axis_ack_tdata_i,
  input  logic [KEEP_WIDTH-1:0] s_axis_ack_tkeep_i,
  input  logic                  s_axis_ack_tvalid_i,
  input  logic                  s_axis_ack_tlast_i,
  input  logic [USER_WIDTH-1:0] s_axis_ack_tuser_i,
  output logic                  s_axis_ack_tready_o,

  input  logic [DATA_WIDTH-1:0] s_axis_fc_tdata_i,
  input  logic [KEEP_WIDTH-1:0] s_axis_fc_tkeep_i,
  input  logic                  s_axis_fc_tvalid_i,
  input  logic                  s_axis_fc_tlast_i,
  input  logic [USER_WIDTH-1:0] s_axis_fc_tuser_i,
  output logic                  s_axis_fc_tready_o,

  input  logic [DATA_WIDTH-1:0] s_axis_tlp_tdata_i,
  input  logic [KEEP_WIDTH-1:0] s_axis_tlp_tkeep_i,
  input  logic                  s_axis_tlp_tvalid_i,
  input  logic                  s_axis_tlp_tlast_i,
  input  logic [USER_WIDTH-1:0] s_axis_tlp_tuser_i,
  output logic                  s_axis_tlp_tready_o,

  output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep_o,
  output logic                  m_axis_tvalid_o,
  output logic                  m_axis_tlast_o,
  output logic [USER_WIDTH-1:0] m_axis_tuser_o,
  input  logic                  m_axis_tready_i,

  output logic [1:0]            grant_o,
  output logic [3:0]            starve_cnt_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_ACK = 2'd1,
    GNT_FC  = 2'd2,
    GNT_TLP = 2'd3
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

  state_t     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       active;
  logic       tlast_hs;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Pure steering: a dropped link blanks the path in the same cycle, before IDLE is reached.
  always_comb begin
    active              = phy_link_up_i && (state_q != IDLE);
    m_axis_tdata_o      = '0;
    m_axis_tkeep_o      = '0;
    m_axis_tvalid_o     = 1'b0;
    m_axis_tlast_o      = 1'b0;
    m_axis_tuser_o      = '0;
    s_axis_ack_tready_o = 1'b0;
    s_axis_fc_tready_o  = 1'b0;
    s_axis_tlp_tready_o = 1'b0;
    if (active) begin
      unique case (state_q)
        GNT_ACK: begin
          m_axis_tdata_o      = s_axis_ack_tdata_i;
          m_axis_tkeep_o      = s_axis_ack_tkeep_i;
          m_axis_tvalid_o     = s_axis_ack_tvalid_i;
          m_axis_tlast_o      = s_axis_ack_tlast_i;
          m_axis_tuser_o      = s_axis_ack_tuser_i;
          m_axis_tuser_o[1:0] = 2'b01;
          s_axis_ack_tready_o = m_axis_tready_i;
        end
        GNT_FC: begin
          m_axis_tdata_o      = s_axis_fc_tdata_i;
          m_axis_tkeep_o      = s_axis_fc_tkeep_i;
          m_axis_tvalid_o     = s_axis_fc_tvalid_i;
          m_axis_tlast_o      = s_axis_fc_tlast_i;
          m_axis_tuser_o      = s_axis_fc_tuser_i;
          m_axis_tuser_o[1:0] = 2'b01;
          s_axis_fc_tready_o  = m_axis_tready_i;
        end
        GNT_TLP: begin
          m_axis_tdata_o      = s_axis_tlp_tdata_i;
          m_axis_tkeep_o      = s_axis_tlp_tkeep_i;
          m_axis_tvalid_o     = s_axis_tlp_tvalid_i;
          m_axis_tlast_o      = s_axis_tlp_tlast_i;
          m_axis_tuser_o      = s_axis_tlp_tuser_i;
          m_axis_tuser_o[1:0] = 2'b10;
          s_axis_tlp_tready_o = m_axis_tready_i;
        end
        default: ;
      endcase
    end
  end

  assign tlast_hs = m_axis_tvalid_o && m_axis_tready_i && m_axis_tlast_o;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    if (!phy_link_up_i) begin
      state_d  = IDLE;
      starve_d = 4'd0;
    end else if (state_q == IDLE) begin
      if (s_axis_tlp_tvalid_i && (starve_q >= STARVE_LIM)) state_d = GNT_TLP;
      else if (s_axis_ack_tvalid_i)                        state_d = GNT_ACK;
      else if (s_axis_fc_tvalid_i)                         state_d = GNT_FC;
      else if (s_axis_tlp_tvalid_i)                        state_d = GNT_TLP;
      // Only a DLLP grant that bypasses a waiting TLP counts towards starvation.
      if (!s_axis_tlp_tvalid_i || (state_d == GNT_TLP)) starve_d = 4'd0;
      else if (starve_q != 4'd15)                       starve_d = starve_q + 4'd1;
    end else if (tlast_hs) begin
      state_d = IDLE;
    end
  end

  assign grant_o      = state_q;
  assign starve_cnt_o = starve_q;

endmodule

// File: tb/tb_dllp_tx_arbiter.sv
// Self-checking bench for dllp_tx_arbiter: vector table, directed corner sequences
// and a randomized run compared against a transaction-level reference model.
module tb_dllp_tx_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        link = 1'b0;
  logic [31:0] s_data  [0:3];
  logic [3:0]  s_keep  [0:3];
  logic        s_valid [0:3];
  logic        s_last  [0:3];
  logic [3:0]  s_user  [0:3];
  logic        s_rdy   [1:3];
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_valid, m_last, m_rdy;
  logic [3:0]  m_user;
  logic [1:0]  grant;
  logic [3:0]  sc;

  int errors = 0;
  int checks = 0;
  int mg, msc;

  always #5 clk = ~clk;

  dllp_tx_arbiter #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .USER_WIDTH(4), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk), .rst_i(rst), .phy_link_up_i(link),
    .s_axis_ack_tdata_i(s_data[1]), .s_axis_ack_tkeep_i(s_keep[1]), .s_axis_ack_tvalid_i(s_valid[1]),
    .s_axis_ack_tlast_i(s_last[1]), .s_axis_ack_tuser_i(s_user[1]), .s_axis_ack_tready_o(s_rdy[1]),
    .s_axis_fc_tdata_i(s_data[2]), .s_axis_fc_tkeep_i(s_keep[2]), .s_axis_fc_tvalid_i(s_valid[2]),
    .s_axis_fc_tlast_i(s_last[2]), .s_axis_fc_tuser_i(s_user[2]), .s_axis_fc_tready_o(s_rdy[2]),
    .s_axis_tlp_tdata_i(s_data[3]), .s_axis_tlp_tkeep_i(s_keep[3]), .s_axis_tlp_tvalid_i(s_valid[3]),
    .s_axis_tlp_tlast_i(s_last[3]), .s_axis_tlp_tuser_i(s_user[3]), .s_axis_tlp_tready_o(s_rdy[3]),
    .m_axis_tdata_o(m_data), .m_axis_tkeep_o(m_keep), .m_axis_tvalid_o(m_valid),
    .m_axis_tlast_o(m_last), .m_axis_tuser_o(m_user), .m_axis_tready_i(m_rdy),
    .grant_o(grant), .starve_cnt_o(sc)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 4; k++) begin
      s_data[k] = '0; s_keep[k] = '0; s_valid[k] = 1'b0; s_last[k] = 1'b0; s_user[k] = '0;
    end
    m_rdy = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    link = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_grant", grant, 0);
    chk("rst_starve", sc, 0);
    chk("rst_mvalid", m_valid, 0);
    rst = 1'b0;
    mg = 0;
    msc = 0;
    @(posedge clk); #1;
  endtask

  // Reference: mg is the source owning the path (0 none), msc the DLLP-bypass tally.
  task automatic model_cycle();
    bit act;
    int ng, nsc;
    act = link && (mg != 0);
    chk("m_grant", grant, mg);
    chk("m_starve", sc, msc);
    chk("m_valid", m_valid, act ? s_valid[mg] : 1'b0);
    if (act && s_valid[mg]) begin
      chk("m_data", m_data, s_data[mg]);
      chk("m_keep", m_keep, s_keep[mg]);
      chk("m_last", m_last, s_last[mg]);
      chk("m_user", m_user, {s_user[mg][3:2], (mg == 3) ? 2'b10 : 2'b01});
    end
    for (int k = 1; k <= 3; k++) chk("m_sready", s_rdy[k], (act && mg == k) ? m_rdy : 1'b0);
    ng = mg;
    nsc = msc;
    if (!link) begin
      ng = 0; nsc = 0;
    end else if (mg == 0) begin
      if (s_valid[3] && msc >= LIMIT) ng = 3;
      else if (s_valid[1])            ng = 1;
      else if (s_valid[2])            ng = 2;
      else if (s_valid[3])            ng = 3;
      else                            ng = 0;
      nsc = (!s_valid[3] || ng == 3) ? 0 : ((msc + 1 > 15) ? 15 : msc + 1);
    end else if (s_valid[mg] && m_rdy && s_last[mg]) begin
      ng = 0;
    end
    @(posedge clk);
    mg = ng;
    msc = nsc;
    #1;
  endtask

  typedef struct {
    bit av, al, fv, fl, tv, tl, rdy;
    bit [1:0] eg;
    bit ev, el;
    bit [3:0] esc, euser;
  } vec_t;

  vec_t vt[10];

  initial begin
    vt[0] = '{1,0,1,0,1,0,1, 0,0,0,0,4'h0};
    vt[1] = '{1,0,1,0,1,0,1, 1,1,0,1,4'h1};
    vt[2] = '{1,1,1,0,1,0,1, 1,1,1,1,4'h1};
    vt[3] = '{0,0,1,0,1,0,1, 0,0,0,1,4'h0};
    vt[4] = '{0,0,1,0,1,0,1, 2,1,0,2,4'h9};
    vt[5] = '{0,0,1,1,1,0,1, 2,1,1,2,4'h9};
    vt[6] = '{0,0,0,0,1,0,1, 0,0,0,2,4'h0};
    vt[7] = '{0,0,0,0,1,0,1, 3,1,0,0,4'h6};
    vt[8] = '{0,0,0,0,1,1,1, 3,1,1,0,4'h6};
    vt[9] = '{0,0,0,0,0,0,1, 0,0,0,0,4'h0};

    // Priority order with tuser tagging, 2-beat packets, one idle cycle between them.
    do_reset();
    link = 1'b1;
    s_data[1] = 32'hA0A0_0001; s_data[2] = 32'hB0B0_0002; s_data[3] = 32'hC0C0_0003;
    s_user[1] = 4'b0000; s_user[2] = 4'b1010; s_user[3] = 4'b0101;
    for (int i = 0; i < 10; i++) begin
      s_valid[1] = vt[i].av; s_last[1] = vt[i].al;
      s_valid[2] = vt[i].fv; s_last[2] = vt[i].fl;
      s_valid[3] = vt[i].tv; s_last[3] = vt[i].tl;
      m_rdy = vt[i].rdy;
      #2;
      chk($sformatf("vec%0d_grant", i), grant, vt[i].eg);
      chk($sformatf("vec%0d_valid", i), m_valid, vt[i].ev);
      chk($sformatf("vec%0d_last", i), m_last, vt[i].el);
      chk($sformatf("vec%0d_starve", i), sc, vt[i].esc);
      chk($sformatf("vec%0d_user", i), m_user, vt[i].euser);
      chk($sformatf("vec%0d_data", i), m_data, (vt[i].eg == 0) ? 32'h0 : s_data[vt[i].eg]);
      for (int k = 1; k <= 3; k++)
        chk($sformatf("vec%0d_rdy%0d", i, k), s_rdy[k], (vt[i].eg == k) ? vt[i].rdy : 1'b0);
      @(posedge clk); #1;
    end

    // Starvation: four ACK packets pass a waiting TLP, then the TLP wins.
    do_reset();
    link = 1'b1; m_rdy = 1'b1;
    s_valid[1] = 1'b1; s_last[1] = 1'b1;
    s_valid[3] = 1'b1; s_last[3] = 1'b0;
    for (int p = 0; p < 5; p++) begin
      #2;
      chk("starve_idle_grant", grant, 0);
      chk("starve_idle_valid", m_valid, 0);
      @(posedge clk); #1;
      #2;
      chk($sformatf("starve_pkt%0d_grant", p), grant, (p < 4) ? 2'd1 : 2'd3);
      chk($sformatf("starve_pkt%0d_cnt", p), sc, (p < 4) ? 4'(p + 1) : 4'd0);
      @(posedge clk); #1;
    end

    // Backpressure on a 4-beat TLP while an FC request arrives mid-packet.
    begin
      int beat;
      bit hs;
      bit pat[4] = '{1, 0, 0, 1};
      do_reset();
      link = 1'b1;
      beat = 0;
      for (int cyc = 0; cyc < 40 && beat < 4; cyc++) begin
        s_valid[3] = 1'b1;
        s_data[3] = 32'h100 + beat;
        s_last[3] = (beat == 3);
        s_valid[2] = (cyc >= 3); s_last[2] = 1'b1;
        m_rdy = pat[cyc % 4];
        #2;
        if (cyc > 0) chk("bp_grant_hold", grant, 3);
        hs = m_valid && m_rdy;
        if (hs) chk($sformatf("bp_beat%0d", beat), m_data, 32'h100 + beat);
        @(posedge clk); #1;
        if (hs) beat++;
      end
      chk("bp_beats_done", beat, 4);
      s_valid[3] = 1'b0; s_last[3] = 1'b0; m_rdy = 1'b1;
      #2;
      chk("bp_gap_grant", grant, 0);
      chk("bp_gap_valid", m_valid, 0);
      @(posedge clk); #1;
      #2;
      chk("bp_fc_after", grant, 2);
      @(posedge clk); #1;
    end

    // Link drop on beat 2 of a TLP.
    do_reset();
    link = 1'b1; m_rdy = 1'b1;
    s_valid[3] = 1'b1; s_last[3] = 1'b0;
    @(posedge clk); #1;
    #2; chk("ld_beat1_grant", grant, 3);
    @(posedge clk); #1;
    link = 1'b0;
    #2; chk("ld_gated_valid", m_valid, 0);
    @(posedge clk); #1;
    #2;
    chk("ld_grant", grant, 0);
    chk("ld_valid", m_valid, 0);
    chk("ld_tlp_rdy", s_rdy[3], 0);
    chk("ld_starve", sc, 0);

    // Asynchronous reset mid-packet, between clock edges.
    link = 1'b1;
    @(posedge clk); #1;
    #2;
    chk("ar_pre_grant", grant, 3);
    chk("ar_pre_valid", m_valid, 1);
    rst = 1'b1;
    #1;
    chk("ar_grant", grant, 0);
    chk("ar_valid", m_valid, 0);
    chk("ar_tlp_rdy", s_rdy[3], 0);
    chk("ar_starve", sc, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Randomized traffic against the reference model.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      link = ($urandom_range(0, 19) != 0);
      for (int k = 1; k <= 3; k++) begin
        s_valid[k] = ($urandom_range(0, 9) < 7);
        s_last[k]  = ($urandom_range(0, 9) < 4);
        s_data[k]  = $urandom;
        s_keep[k]  = 4'($urandom);
        s_user[k]  = 4'($urandom);
      end
      m_rdy = ($urandom_range(0, 9) < 7);
      #1;
      model_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dllp_tx_arbiter.md
DLLP_TX_ARBITER -- requirements
Module: dllp_tx_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, tdata width; KEEP_WIDTH, default DATA_WIDTH/8, tkeep width; USER_WIDTH, default 4, tuser width; STARVE_LIMIT, default 4, consecutive DLLP grants allowed while a TLP waits (range 1-15).
REQ-002 There SHALL be one clock; reset SHALL be asynchronous and active-high.
REQ-003 The ports SHALL be, in this order:
- clk_i, in, 1, clock.
- rst_i, in, 1, asynchronous active-high reset.
- phy_link_up_i, in, 1, physical link up.
- s_axis_ack_*, slave AXIS (tdata, tkeep, tvalid, tlast, tuser, tready; widths per parameters), ACK/NAK DLLP source.
- s_axis_fc_*, slave AXIS, same signal set, UpdateFC DLLP source.
- s_axis_tlp_*, slave AXIS, same signal set, TLP source (retry buffer).
- m_axis_*, master AXIS, same signal set, shared path to the physical layer.
- grant_o, out, 2, current grant: 0 none, 1 ack, 2 fc, 3 tlp.
- starve_cnt_o, out, 4, consecutive DLLP-grant counter.

Function
REQ-004 The FSM SHALL have states IDLE, GNT_ACK, GNT_FC and GNT_TLP, and grant_o SHALL encode the state.
REQ-005 In IDLE with phy_link_up_i=1, arbitration SHALL pick among sources with tvalid=1, and the FSM SHALL enter the granted state on the next edge.
REQ-006 Default priority SHALL be ACK > FC > TLP.
REQ-007 If starve_cnt_o >= STARVE_LIMIT and s_axis_tlp_tvalid=1, TLP SHALL win over both DLLP sources.
REQ-008 In a GNT state, m_axis_tdata, tkeep, tvalid and tlast SHALL equal the granted source's signals combinationally.
REQ-009 In a GNT state, the granted source's tready SHALL equal m_axis_tready; all other treadys SHALL be 0.
REQ-010 m_axis_tuser SHALL be the source tuser with bit0 forced to 1 and bit1 forced to 0 for ACK and FC, and bit0 forced to 0 and bit1 forced to 1 for TLP.
REQ-011 A grant SHALL hold until a handshake (m_axis_tvalid & m_axis_tready) with tlast=1; the FSM SHALL then return to IDLE, with no re-arbitration mid-packet.
REQ-012 There SHALL be exactly one idle cycle (m_axis_tvalid=0) between consecutive packets.
REQ-013 In IDLE, m_axis_tvalid SHALL be 0 and all treadys SHALL be 0.
REQ-014 The starve counter SHALL update at the arbitration edge:
- DLLP granted while s_axis_tlp_tvalid=1: increment, saturating at 15.
- TLP granted: clear to 0.
- Arbitration with s_axis_tlp_tvalid=0: clear to 0.
REQ-015 phy_link_up_i=0 in any state SHALL force IDLE on the next edge and clear the counter; a partial packet SHALL be abandoned and not resumed.
REQ-016 While phy_link_up_i=0, no grant SHALL be issued, m_axis_tvalid SHALL be 0 and all treadys SHALL be 0.
REQ-017 A source dropping tvalid mid-packet SHALL keep its grant; m_axis_tvalid SHALL follow that source's tvalid.
REQ-018 Simultaneous tlast handshake and new requests SHALL be handled as IDLE on the next cycle, then arbitration per REQ-005 to REQ-007.
REQ-019 m_axis_tready=0 SHALL stall the granted source with no data loss; the arbiter SHALL contain no data storage.

Reset
REQ-020 While rst_i=1, the state SHALL be IDLE, grant_o=0, starve_cnt_o=0, m_axis_tvalid=0 and all treadys=0.
REQ-021 After rst_i deasserts, the first grant SHALL occur no earlier than the first edge on which phy_link_up_i=1 and a tvalid=1.
REQ-022 Reset asserted mid-packet SHALL immediately deassert m_axis_tvalid and all treadys.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Priority: link up; ack, fc and tlp all valid, each a 2-beat packet, tready=1 -> output order ack, fc, tlp; grant_o sequence 1,2,3; one idle cycle between packets.
- Starvation: STARVE_LIMIT=4; ack valid continuously with 1-beat packets; tlp valid -> 4 ack packets, then the tlp packet; starve_cnt_o 1,2,3,4, then 0.
- Backpressure: TLP 4-beat packet; m_axis_tready toggles 1,0,0,1,... -> all 4 beats delivered in order; fc request raised mid-packet waits until after tlast.
- tuser tagging: ack input tuser=4'b0000 -> m_axis_tuser=4'b0001; tlp input tuser=4'b0101 -> m_axis_tuser=4'b0110.
- Link drop: phy_link_up_i falls on beat 2 of a 4-beat TLP -> next cycle grant_o=0, m_axis_tvalid=0, s_axis_tlp_tready=0, starve_cnt_o=0.
- Async reset: rst_i pulsed between clock edges mid-packet -> outputs take reset values immediately, without waiting for a clock edge.
